// File: rtl/vc_status_manager_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_status_manager_pkg
// Description : Shared NIC definitions for the per-VC status tracking logic.
//               Holds the VC FSM state encoding and the default downstream
//               buffer depth (the maximum credit count per VC).
// Revision    : 1.0 - initial release
// ============================================================================
package vc_status_manager_pkg;

    typedef logic [1:0] vc_state_t;

    localparam vc_state_t c_st_idle   = 2'd0;
    localparam vc_state_t c_st_active = 2'd1;
    localparam vc_state_t c_st_drain  = 2'd2;

    localparam int c_default_credit_depth = 4;

endpackage
`default_nettype wire

// File: rtl/vc_credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : vc_credit_counter
// Description : State machine and credit counter for one virtual channel.
//               Qualifies the grant, send and credit events of this VC against
//               the current state, applies the legal ones and flags the rest.
// Ports       : clk, rst (async, active-low)
//               i_grant        - one-hot-qualified VA grant for this VC
//               i_send         - a flit leaves on this VC
//               i_tail         - the sent flit is a tail
//               i_credit       - one credit returned to this VC
//               o_vc_free      - IDLE with a full credit count
//               o_credit_avail - credit count is non-zero
//               o_err          - an event on this VC this cycle is illegal
// Revision    : 1.0 - initial release
// ============================================================================
module vc_credit_counter
    import vc_status_manager_pkg::*;
#(
    parameter int CREDIT_DEPTH  = c_default_credit_depth,
    parameter int N_BITS_CREDIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_grant,
    input  logic i_send,
    input  logic i_tail,
    input  logic i_credit,
    output logic o_vc_free,
    output logic o_credit_avail,
    output logic o_err
);

    localparam logic [N_BITS_CREDIT-1:0] c_full = N_BITS_CREDIT'(CREDIT_DEPTH);
    localparam logic [N_BITS_CREDIT-1:0] c_zero = '0;
    localparam logic [N_BITS_CREDIT-1:0] c_one  = N_BITS_CREDIT'(1);

    vc_state_t                r_state;
    vc_state_t                w_state_nxt;
    logic [N_BITS_CREDIT-1:0] r_count;
    logic [N_BITS_CREDIT-1:0] w_count_nxt;

    logic w_free;
    logic w_grant_ok;
    logic w_send_ok;
    logic w_credit_ok;

    assign w_free      = (r_state == c_st_idle) && (r_count == c_full);
    assign w_grant_ok  = i_grant && w_free;
    assign w_send_ok   = i_send && (r_state == c_st_active) && (r_count != c_zero);
    // A credit at full count is only acceptable when a legal send in the same
    // cycle frees a slot; otherwise it would push the counter past the depth.
    assign w_credit_ok = i_credit && ((r_count != c_full) || w_send_ok);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_count <= c_full;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_count_nxt = r_count;
        if (w_send_ok && !w_credit_ok) begin
            w_count_nxt = r_count - c_one;
        end else if (!w_send_ok && w_credit_ok) begin
            w_count_nxt = r_count + c_one;
        end

        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_grant_ok) begin
                    w_state_nxt = c_st_active;
                end
            end
            c_st_active: begin
                // A tail sent while every slot is simultaneously refilled
                // skips DRAIN entirely.
                if (w_send_ok && i_tail) begin
                    w_state_nxt = (w_count_nxt == c_full) ? c_st_idle : c_st_drain;
                end
            end
            c_st_drain: begin
                if (w_count_nxt == c_full) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        o_vc_free      = w_free;
        o_credit_avail = (r_count != c_zero);
        o_err          = (i_grant  && !w_free)     ||
                         (i_send   && !w_send_ok)  ||
                         (i_credit && !w_credit_ok);
    end

endmodule
`default_nettype wire

// File: rtl/vc_status_manager.sv
`default_nettype none
// ============================================================================
// Module      : vc_status_manager
// Description : Tracks allocation state and downstream credits for every VC
//               of one output port. One vc_credit_counter per VC; port-level
//               checks (grant one-hotness, VC index range) and the sticky
//               error flag live here.
// Ports       : clk, rst (async, active-low)
//               g_vc_i            - one-hot VA grant
//               flit_sent_i       - flit sent on VC flit_vc_id_i
//               flit_vc_id_i      - VC index of the sent flit
//               flit_tail_i       - sent flit is a tail
//               credit_i          - per-VC credit return
//               vc_free_o         - VC allocatable (feeds VA vc_free)
//               vc_credit_avail_o - VC has at least one credit
//               error_o           - sticky protocol-violation flag
// Revision    : 1.0 - initial release
// ============================================================================
module vc_status_manager
    import vc_status_manager_pkg::*;
#(
    parameter int N_OF_VC        = 2,
    parameter int N_BITS_N_OF_VC = 1,
    parameter int CREDIT_DEPTH   = c_default_credit_depth,
    parameter int N_BITS_CREDIT  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_OF_VC-1:0]        g_vc_i,
    input  logic                      flit_sent_i,
    input  logic [N_BITS_N_OF_VC-1:0] flit_vc_id_i,
    input  logic                      flit_tail_i,
    input  logic [N_OF_VC-1:0]        credit_i,
    output logic [N_OF_VC-1:0]        vc_free_o,
    output logic [N_OF_VC-1:0]        vc_credit_avail_o,
    output logic                      error_o
);

    logic               w_grant_onehot0;
    logic               w_id_valid;
    logic [N_OF_VC-1:0] w_vc_err;
    logic               w_event_err;
    logic               r_error;

    // Clearing the lowest set bit leaves zero only for zero or one-hot.
    assign w_grant_onehot0 = ((g_vc_i & (g_vc_i - N_OF_VC'(1))) == '0);

    // One extra bit keeps the range compare meaningful when N_OF_VC is a
    // power of two.
    assign w_id_valid = ({1'b0, flit_vc_id_i} < (N_BITS_N_OF_VC + 1)'(N_OF_VC));

    for (genvar v = 0; v < N_OF_VC; v++) begin : g_vc
        vc_credit_counter #(
            .CREDIT_DEPTH  (CREDIT_DEPTH),
            .N_BITS_CREDIT (N_BITS_CREDIT)
        ) u_counter (
            .clk            (clk),
            .rst            (rst),
            .i_grant        (g_vc_i[v] && w_grant_onehot0),
            .i_send         (flit_sent_i && w_id_valid &&
                             (flit_vc_id_i == N_BITS_N_OF_VC'(v))),
            .i_tail         (flit_tail_i),
            .i_credit       (credit_i[v]),
            .o_vc_free      (vc_free_o[v]),
            .o_credit_avail (vc_credit_avail_o[v]),
            .o_err          (w_vc_err[v])
        );
    end

    assign w_event_err = (|w_vc_err)                  ||
                         (flit_sent_i && !w_id_valid) ||
                         !w_grant_onehot0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_error <= 1'b0;
        end else if (w_event_err) begin
            r_error <= 1'b1;
        end
    end

    assign error_o = r_error;

endmodule
`default_nettype wire

// File: tb/tb_vc_status_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_status_manager
// Description : Self-checking bench for vc_status_manager. A behavioural
//               model tracks each VC as (state, credit count) plus a sticky
//               error bit; a compare process checks the outputs every cycle.
//               Directed scenarios pin the model with literal expectations,
//               then randomized segments separated by mid-cycle resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_status_manager;

    localparam int N   = 2;
    localparam int NB  = 1;
    localparam int D   = 4;
    localparam int NBC = 3;

    localparam int S_IDLE   = 0;
    localparam int S_ACTIVE = 1;
    localparam int S_DRAIN  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  g_vc = '0;
    logic          sent = 1'b0;
    logic [NB-1:0] id = '0;
    logic          tail = 1'b0;
    logic [N-1:0]  credit = '0;
    logic [N-1:0]  vc_free_o;
    logic [N-1:0]  vc_credit_avail_o;
    logic          error_o;

    int n_checks = 0;
    int n_errors = 0;

    int m_state [N];
    int m_count [N];
    bit m_err;

    vc_status_manager #(
        .N_OF_VC        (N),
        .N_BITS_N_OF_VC (NB),
        .CREDIT_DEPTH   (D),
        .N_BITS_CREDIT  (NBC)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .g_vc_i            (g_vc),
        .flit_sent_i       (sent),
        .flit_vc_id_i      (id),
        .flit_tail_i       (tail),
        .credit_i          (credit),
        .vc_free_o         (vc_free_o),
        .vc_credit_avail_o (vc_credit_avail_o),
        .error_o           (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        for (int v = 0; v < N; v++) begin
            m_state[v] = S_IDLE;
            m_count[v] = D;
        end
        m_err = 1'b0;
    endtask

    task automatic model_step();
        int  ones;
        bit  e;
        ones = $countones(g_vc);
        e    = 1'b0;
        if (ones > 1) e = 1'b1;
        if (sent && (int'(id) >= N)) e = 1'b1;
        for (int v = 0; v < N; v++) begin
            int st, c, nc, ns;
            bit free, grant, snd, snd_ok, crd_ok;
            st     = m_state[v];
            c      = m_count[v];
            free   = (st == S_IDLE) && (c == D);
            grant  = g_vc[v] && (ones == 1);
            snd    = sent && (int'(id) == v);
            snd_ok = snd && (st == S_ACTIVE) && (c > 0);
            // room check is made on the count after this cycle's send
            crd_ok = credit[v] && ((c - int'(snd_ok)) < D);
            if (grant && !free)       e = 1'b1;
            if (snd && !snd_ok)       e = 1'b1;
            if (credit[v] && !crd_ok) e = 1'b1;
            nc = c - int'(snd_ok) + int'(crd_ok);
            ns = st;
            if (st == S_IDLE && grant && free)   ns = S_ACTIVE;
            if (st == S_ACTIVE && snd_ok && tail) ns = (nc == D) ? S_IDLE : S_DRAIN;
            if (st == S_DRAIN && nc == D)         ns = S_IDLE;
            m_state[v] = ns;
            m_count[v] = nc;
        end
        m_err = m_err | e;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [N-1:0] e_free, e_avail;
        for (int v = 0; v < N; v++) begin
            e_free[v]  = (m_state[v] == S_IDLE) && (m_count[v] == D);
            e_avail[v] = (m_count[v] != 0);
        end
        chk("model_vc_free", 32'(vc_free_o), 32'(e_free));
        chk("model_credit_avail", 32'(vc_credit_avail_o), 32'(e_avail));
        chk("model_error", 32'(error_o), 32'(m_err));
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_in();
        g_vc = '0; sent = 1'b0; id = '0; tail = 1'b0; credit = '0;
    endtask

    task automatic cyc(input logic [N-1:0] g, input logic s, input logic [NB-1:0] i,
                       input logic t, input logic [N-1:0] c);
        g_vc = g; sent = s; id = i; tail = t; credit = c;
        @(posedge clk);
        #1;
        idle_in();
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        int v;
        idle_in();
        v = $urandom_range(0, N - 1);
        if ((m_state[v] == S_IDLE) && (m_count[v] == D)) begin
            if ($urandom_range(0, 2) == 0) g_vc[v] = 1'b1;
        end else if ($urandom_range(0, 39) == 0) begin
            g_vc[v] = 1'b1;
        end
        if ($urandom_range(0, 59) == 0) g_vc = '1;
        v  = $urandom_range(0, N - 1);
        id = NB'(v);
        if ((m_state[v] == S_ACTIVE) && (m_count[v] > 0)) begin
            sent = ($urandom_range(0, 3) != 0);
            tail = ($urandom_range(0, 3) == 0);
        end else begin
            sent = ($urandom_range(0, 39) == 0);
        end
        for (int k = 0; k < N; k++) begin
            if (m_count[k] < D) credit[k] = ($urandom_range(0, 1) == 1);
            else                credit[k] = ($urandom_range(0, 39) == 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        idle_in();
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset then idle
        for (int k = 0; k < 10; k++) begin
            chk("idle_after_reset", 32'({vc_free_o, vc_credit_avail_o, error_o}), 32'b11110);
            @(posedge clk);
            #1;
        end

        // Full packet on VC1
        cyc(2'b10, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("vc1_grant_free", 32'(vc_free_o), 32'b01);
        for (int k = 0; k < 4; k++) begin
            cyc(2'b00, 1'b1, 1'b1, (k == 3), 2'b00);
            chk("vc1_send_avail", 32'(vc_credit_avail_o[1]), (k == 3) ? 32'd0 : 32'd1);
        end
        chk("vc1_in_drain", 32'(dut.g_vc[1].u_counter.r_state), 32'd2);
        for (int k = 0; k < 4; k++) begin
            cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b10);
            chk("vc1_drain_free", 32'(vc_free_o), (k == 3) ? 32'b11 : 32'b01);
        end
        chk("vc1_packet_error", 32'(error_o), 32'd0);

        // Send and credit in the same cycle on VC0
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
        cyc(2'b00, 1'b1, 1'b0, 1'b0, 2'b01);
        chk("vc0_same_cycle_count", 32'(dut.g_vc[0].u_counter.r_count), 32'd4);
        chk("vc0_same_cycle_error", 32'(error_o), 32'd0);
        chk("vc0_same_cycle_free", 32'(vc_free_o), 32'b10);
        // Tail with simultaneous refill goes straight back to IDLE
        cyc(2'b00, 1'b1, 1'b0, 1'b1, 2'b01);
        chk("vc0_tail_refill_free", 32'(vc_free_o), 32'b11);
        chk("vc0_tail_refill_error", 32'(error_o), 32'd0);

        // Credit on a full idle VC1
        cyc(2'b00, 1'b0, 1'b0, 1'b0, 2'b10);
        chk("vc1_overflow_error", 32'(error_o), 32'd1);
        chk("vc1_overflow_count", 32'(dut.g_vc[1].u_counter.r_count), 32'd4);
        chk("vc1_overflow_avail", 32'(vc_credit_avail_o), 32'b11);

        do_reset();
        chk("error_cleared_by_reset", 32'(error_o), 32'd0);

        // Non-one-hot grant is ignored
        cyc(2'b11, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("multi_grant_error", 32'(error_o), 32'd1);
        chk("multi_grant_free", 32'(vc_free_o), 32'b11);
        do_reset();

        // Double grant on VC0
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("vc0_first_grant_error", 32'(error_o), 32'd0);
        cyc(2'b01, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("vc0_double_grant_error", 32'(error_o), 32'd1);
        chk("vc0_double_grant_state", 32'(dut.g_vc[0].u_counter.r_state), 32'd1);
        chk("vc0_double_grant_free", 32'(vc_free_o), 32'b10);

        // Asynchronous reset mid-packet
        cyc(2'b00, 1'b1, 1'b0, 1'b0, 2'b00);
        chk("vc0_mid_packet_count", 32'(dut.g_vc[0].u_counter.r_count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({vc_free_o, vc_credit_avail_o, error_o}), 32'b11110);
        chk("async_reset_count", 32'(dut.g_vc[0].u_counter.r_count), 32'd4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Randomized segments
        for (int seg = 0; seg < 20; seg++) begin
            do_reset();
            for (int k = 0; k < 60; k++) begin
                rand_inputs();
                @(posedge clk);
                #1;
            end
            idle_in();
        end

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vc_status_manager.md
VC_STATUS_MANAGER -- requirements
Module: vc_status_manager

Interface
REQ-001 Parameter N_OF_VC, default 2: number of virtual channels tracked on one output port.
REQ-002 Parameter N_BITS_N_OF_VC, default 1: width of a VC index.
REQ-003 Parameter CREDIT_DEPTH, default 4: downstream buffer slots per VC, which is also the maximum credit count.
REQ-004 Parameter N_BITS_CREDIT, default 3: counter width; it SHALL hold 0..CREDIT_DEPTH.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 g_vc_i  input  N_OF_VC  one-hot VC allocation grant from the VA stage.
REQ-008 flit_sent_i  input  1  a flit leaves on the VC given by flit_vc_id_i this cycle.
REQ-009 flit_vc_id_i  input  N_BITS_N_OF_VC  VC index of the sent flit.
REQ-010 flit_tail_i  input  1  the sent flit is a tail flit.
REQ-011 credit_i  input  N_OF_VC  one credit is returned per set bit this cycle.
REQ-012 vc_free_o  output  N_OF_VC  the VC is IDLE and allocatable; this output feeds the VA vc_free input.
REQ-013 vc_credit_avail_o  output  N_OF_VC  the VC credit count is greater than 0.
REQ-014 error_o  output  1  sticky protocol-violation flag.

Function
REQ-015 Each VC SHALL run an independent FSM with states IDLE, ACTIVE and DRAIN, plus a credit counter.
REQ-016 IDLE->ACTIVE SHALL occur on g_vc_i[v]=1; the transition is accepted only if vc_free_o[v]=1 in the same cycle.
REQ-017 In ACTIVE, flit_sent_i with flit_vc_id_i=v SHALL decrement count[v]; if flit_tail_i=1, the next state SHALL be DRAIN.
REQ-018 In DRAIN or ACTIVE-with-tail, if the next count equals CREDIT_DEPTH, the next state SHALL be IDLE directly.
REQ-019 In DRAIN, credits SHALL increment count[v]; the VC returns to IDLE in the cycle after the count reaches CREDIT_DEPTH.
REQ-020 Credit returns SHALL be accepted in every state, including ACTIVE.
REQ-021 A flit send and a credit return on the same VC in the same cycle SHALL leave count unchanged (next = count - 1 + 1).
REQ-022 All outputs SHALL be registered or decoded from registered state only; there is no combinational input-to-output path.
REQ-023 vc_free_o[v] SHALL deassert in the cycle after the grant edge (one-cycle latency).
REQ-024 vc_free_o[v] SHALL be 1 only in IDLE with count = CREDIT_DEPTH.
REQ-025 vc_credit_avail_o[v] SHALL equal (count[v] != 0).
REQ-026 Any of the following SHALL set error_o, and the illegal action SHALL be ignored with no state or count change for the offending event:
- a grant to a VC that is not free;
- g_vc_i not one-hot or zero;
- flit_sent_i to a VC not in ACTIVE;
- flit_sent_i with count = 0;
- a credit return with count = CREDIT_DEPTH (no wrap);
- flit_vc_id_i >= N_OF_VC.
REQ-027 When an event is illegal, other legal events in the same cycle on other VCs SHALL still be applied.
REQ-028 Counter arithmetic SHALL saturate-check before the update, and the counter SHALL never wrap.

Reset
REQ-029 While rst=0, independently of clk, all VCs SHALL be in IDLE with count = CREDIT_DEPTH and error_o = 0.
REQ-030 Reset outputs: vc_free_o = all ones, vc_credit_avail_o = all ones, error_o = 0.
REQ-031 Reset asserted mid-packet SHALL abandon all VC state; no pending credits are remembered.
REQ-032 Deassertion is synchronised externally; the block SHALL act on inputs from the first rising edge after rst=1.

Structure
REQ-033 The FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, DRAIN=2'd2) and the default CREDIT_DEPTH SHALL live in the shared NIC package/defines.
REQ-034 One sub-module, vc_credit_counter, SHALL hold the per-VC FSM and counter; it SHALL be instantiated N_OF_VC times, with error aggregation at the top.

Verification
REQ-035 Reset then idle: vc_free_o = 2'b11, vc_credit_avail_o = 2'b11, error_o = 0 for 10 cycles.
REQ-036 Grant VC1, then send 4 flits (tail on the 4th), then return 4 credits:
- vc_free_o[1] = 0 from the cycle after the grant;
- vc_credit_avail_o[1] = 0 after the 4th send;
- VC1 in DRAIN after the 4th send;
- vc_free_o[1] = 1 one cycle after the 4th credit.
REQ-037 Grant VC0, send one flit and return one credit on VC0 in the same cycle: count stays 4 and error_o = 0.
REQ-038 Grant VC0 twice without an intervening tail: error_o = 1 from the cycle after the second grant, and VC0 remains ACTIVE.
REQ-039 Credit return on an IDLE, full VC1: error_o = 1 and count stays 4 (no wrap to 0).
REQ-040 Assert rst=0 mid-packet on VC0 between clock edges: outputs return to their reset values immediately, before the next clk edge.
